// File: rtl/pulse_checker_pkg.sv
// Shared types and constants for the pulse interval checker.
package pulse_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int ERRCNT_W = 8;
    localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = 8'hFF;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at MAX instead of wrapping.
module sat_counter #(
    parameter int          W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_checker.sv
// Measures the interval between single-cycle pulses, declares lock and flags early/late pulses.
// Optional saturating error counter enabled by defining PULSE_CHECKER_ERRCNT_EN.
module pulse_checker
    import pulse_checker_pkg::*;
#(
    parameter int PERIOD     = 5,
    parameter int LOCK_COUNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                signal_in,
    output logic                locked,
    output logic                early_err,
    output logic                late_err,
    output logic [CNT_W-1:0]    period_out,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int                GR_W      = $clog2(LOCK_COUNT + 1);
    localparam logic [GR_W-1:0]   GR_MAX    = GR_W'(LOCK_COUNT);
    localparam logic [GR_W-1:0]   LOCK_LAST = GR_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0]  PER_M1    = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  PER_VAL   = CNT_W'(PERIOD);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [CNT_W-1:0]  period_nx;
    logic              early_nx, late_nx;
    logic              gr_inc, gr_clr;
    logic [GR_W-1:0]   good_run;

    sat_counter #(.W(GR_W), .MAX(GR_MAX)) u_good_run (
        .clk   (clk),
        .reset (reset),
        .clr   (gr_clr),
        .inc   (gr_inc),
        .q     (good_run)
    );

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        period_nx = period_out;
        early_nx  = 1'b0;
        late_nx   = 1'b0;
        gr_inc    = 1'b0;
        gr_clr    = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            gr_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (signal_in) begin
                        state_nx = HUNT;
                        cnt_nx   = '0;
                    end
                end
                HUNT, LOCKED: begin
                    if (signal_in) begin
                        // Every sampled pulse becomes the reference for the next interval.
                        cnt_nx = '0;
                        if (cnt == PER_M1) begin
                            period_nx = PER_VAL;
                            gr_inc    = 1'b1;
                            if ((state == HUNT) && (good_run == LOCK_LAST)) begin
                                state_nx = LOCKED;
                            end
                        end else begin
                            early_nx  = 1'b1;
                            period_nx = cnt + 1'b1;
                            gr_clr    = 1'b1;
                            state_nx  = HUNT;
                        end
                    end else if (cnt == PER_M1) begin
                        late_nx  = 1'b1;
                        gr_clr   = 1'b1;
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    gr_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            locked     <= 1'b0;
            early_err  <= 1'b0;
            late_err   <= 1'b0;
            period_out <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            locked     <= (state_nx == LOCKED);
            early_err  <= early_nx;
            late_err   <= late_nx;
            period_out <= period_nx;
        end
    end

`ifdef PULSE_CHECKER_ERRCNT_EN
    sat_counter #(.W(ERRCNT_W), .MAX(ERRCNT_MAX)) u_err_count (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (early_nx | late_nx),
        .q     (err_count)
    );
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_pulse_checker.sv
// Directed and randomized bench for pulse_checker against an interval-based reference model.
module tb_pulse_checker;

    localparam int PERIOD     = 5;
    localparam int LOCK_COUNT = 3;
    localparam int CNT_W      = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             signal_in;
    logic             locked;
    logic             early_err;
    logic             late_err;
    logic [CNT_W-1:0] period_out;
    logic [7:0]       err_count;

    int total = 0;
    int bad   = 0;

    // Reference model state: time of the last pulse and how many good intervals in a row.
    int cyc      = 0;
    int last_p   = 0;
    bit anchored = 0;
    int run      = 0;
    bit m_lock   = 0;
    bit m_early  = 0;
    bit m_late   = 0;
    int m_period = 0;
    int m_err    = 0;

    pulse_checker #(.PERIOD(PERIOD), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .signal_in  (signal_in),
        .locked     (locked),
        .early_err  (early_err),
        .late_err   (late_err),
        .period_out (period_out),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("locked",     32'(locked),     32'(m_lock));
        chk("early_err",  32'(early_err),  32'(m_early));
        chk("late_err",   32'(late_err),   32'(m_late));
        chk("period_out", 32'(period_out), 32'(m_period));
        chk("err_count",  32'(err_count),  32'(m_err));
    endtask

    task automatic model_reset();
        anchored = 0; run = 0; m_lock = 0; m_early = 0; m_late = 0;
        m_period = 0; m_err = 0;
    endtask

    task automatic model_step(input logic en, input logic s);
        int iv;
        cyc++;
        m_early = 0;
        m_late  = 0;
        if (!en) begin
            anchored = 0; run = 0; m_lock = 0;
        end else if (s) begin
            if (anchored) begin
                iv = cyc - last_p;
                if (iv == PERIOD) begin
                    m_period = PERIOD;
                    run = (run + 1 > LOCK_COUNT) ? LOCK_COUNT : run + 1;
                    if (run >= LOCK_COUNT) m_lock = 1;
                end else begin
                    m_early = 1; m_period = iv; run = 0; m_lock = 0;
                end
            end
            anchored = 1;
            last_p   = cyc;
        end else if (anchored && (cyc - last_p == PERIOD)) begin
            m_late = 1; anchored = 0; run = 0; m_lock = 0;
        end
`ifdef PULSE_CHECKER_ERRCNT_EN
        if ((m_early || m_late) && m_err < 255) m_err++;
`endif
    endtask

    task automatic cycle(input logic en, input logic s);
        @(negedge clk);
        enable    = en;
        signal_in = s;
        @(posedge clk);
        model_step(en, s);
        #1;
        check_all();
    endtask

    task automatic pulse(input int gap, input logic en);
        for (int i = 1; i < gap; i++) cycle(en, 1'b0);
        cycle(en, 1'b1);
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) cycle(en, 1'b0);
    endtask

    initial begin
        int gap;
        reset = 1'b0; enable = 1'b0; signal_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        reset = 1'b1;

        // Clean acquisition: anchor + LOCK_COUNT correct intervals.
        pulse(1, 1'b1);
        pulse(PERIOD, 1'b1);
        pulse(PERIOD, 1'b1);
        chk("not_locked_yet", 32'(locked), 32'd0);
        pulse(PERIOD, 1'b1);
        chk("locked_4th", 32'(locked), 32'd1);
        chk("period_5", 32'(period_out), 32'd5);

        // Early pulse while locked, then relock.
        pulse(3, 1'b1);
        chk("early_flag", 32'(early_err), 32'd1);
        chk("early_period", 32'(period_out), 32'd3);
        chk("early_unlock", 32'(locked), 32'd0);
        for (int i = 0; i < 3; i++) pulse(PERIOD, 1'b1);
        chk("relock_early", 32'(locked), 32'd1);

        // Missing pulse while locked.
        idle(PERIOD, 1'b1);
        chk("late_flag", 32'(late_err), 32'd1);
        chk("late_unlock", 32'(locked), 32'd0);
        pulse(1, 1'b1);
        for (int i = 0; i < 3; i++) pulse(PERIOD, 1'b1);
        chk("relock_late", 32'(locked), 32'd1);

        // Enable dropped for two cycles while locked.
        idle(2, 1'b1);
        cycle(1'b0, 1'b0);
        chk("en_unlock", 32'(locked), 32'd0);
        chk("en_period_hold", 32'(period_out), 32'd5);
        cycle(1'b0, 1'b0);
        pulse(1, 1'b1);
        for (int i = 0; i < 3; i++) pulse(PERIOD, 1'b1);
        idle(2, 1'b1);

        // Asynchronous reset mid-interval, no clock edge in between.
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        reset = 1'b1;
        pulse(1, 1'b1);
        chk("post_reset_anchor", 32'(locked), 32'd0);
        for (int i = 0; i < 3; i++) pulse(PERIOD, 1'b1);

        // Randomized gaps, bursts and enable drops.
        for (int n = 0; n < 400; n++) begin
            gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : PERIOD;
            for (int i = 1; i <= gap; i++)
                cycle($urandom_range(0, 24) != 0, i == gap);
        end

        // Error storm: one early and one late per iteration.
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        reset = 1'b1;
        for (int n = 0; n < 150; n++) begin
            pulse(1, 1'b1);
            pulse(2, 1'b1);
            idle(PERIOD, 1'b1);
        end
`ifdef PULSE_CHECKER_ERRCNT_EN
        chk("errcnt_sat", 32'(err_count), 32'd255);
`else
        chk("errcnt_zero", 32'(err_count), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
